// File: rtl/ws2812b_pattern_seq_if.sv
// Pixel stream handshake between the pattern sequencer and the serializer.
// Master drives GRB words; slave returns ready.
interface ws2812b_pattern_seq_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/ws2812b_pattern_seq.sv
// Frame-rate chase pattern source: one colour, triangle brightness ramp,
// colour and chase head advance each time the ramp returns to zero.
module ws2812b_pattern_seq #(
  parameter int        NUM_LEDS     = 8,
  parameter int        FRAME_CYCLES = 540000,
  parameter logic [7:0] MAX_LEVEL   = 8'd16,
  parameter logic [7:0] STEP        = 8'd1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  ws2812b_pattern_seq_if.master pix,
  output logic                  frame_start_o,
  output logic                  overrun_o
);

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
  localparam logic [TW-1:0] TMAX     = TW'(FRAME_CYCLES - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    level_q, level_d;
  logic          dir_q, dir_d;
  logic [1:0]    color_q, color_d;
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fs_q, fs_d;
  logic          ovr_q, ovr_d;

  logic       tick;
  logic       xfer;
  logic       valid;
  logic [8:0] lvl9;
  logic [8:0] step9;
  logic [8:0] up9;
  logic [7:0] chan;
  logic [23:0] word;

  assign tick  = en_i && (timer_q == TMAX);
  assign valid = (state_q == STREAM);
  assign xfer  = valid && pix.pix_ready;

  assign lvl9  = {1'b0, level_q};
  assign step9 = {1'b0, STEP};
  assign up9   = lvl9 + step9;

  always_comb begin
    timer_d = timer_q;
    if (!en_i) begin
      timer_d = '0;
    end else if (timer_q == TMAX) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dir_d   = dir_q;
    color_d = color_q;
    head_d  = head_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = STREAM;
          idx_d   = '0;
          fs_d    = 1'b1;
          // dir_q: 0 = ramping up, 1 = ramping down
          if (!dir_q) begin
            if (up9 >= {1'b0, MAX_LEVEL}) begin
              level_d = MAX_LEVEL;
              dir_d   = 1'b1;
            end else begin
              level_d = up9[7:0];
            end
          end else begin
            if (lvl9 <= step9) begin
              level_d = '0;
              dir_d   = 1'b0;
              color_d = (color_q == 2'd2) ?
                        2'd0 : color_q + 2'd1;
              head_d  = (head_q == LAST_IDX) ?
                        '0 : head_q + 1'b1;
            end else begin
              level_d = level_q - STEP;
            end
          end
        end
      end
      STREAM: begin
        if (tick) begin
          ovr_d = 1'b1;
        end
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chan = (idx_q == head_q) ? level_q : (level_q >> 3);
    word = '0;
    unique case (1'b1)
      (color_q == 2'd0): word = {chan, 16'h0000};
      (color_q == 2'd1): word = {8'h00, chan, 8'h00};
      (color_q == 2'd2): word = {16'h0000, chan};
      default:           word = '0;
    endcase
  end

  assign pix.pix_valid = valid;
  assign pix.pix_data  = valid ? word : 24'h0;
  assign pix.pix_last  = valid && (idx_q == LAST_IDX);
  assign frame_start_o = fs_q;
  assign overrun_o     = ovr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      level_q <= '0;
      dir_q   <= 1'b0;
      color_q <= 2'd0;
      head_q  <= '0;
      idx_q   <= '0;
      fs_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      color_q <= color_d;
      head_q  <= head_d;
      idx_q   <= idx_d;
      fs_q    <= fs_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule
